// File: rtl/iface_data_driver_if.sv
// Data interface I: one producer writes data through modport D, consumers read it through modport P.
interface I #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] data;

  modport D (output data);
  modport P (input  data);
endinterface

// File: rtl/iface_data_driver.sv
// Producer-side driver for interface I: emits a bounded arithmetic sequence on i.data
// under a start/done handshake, with a direct-load path for arbitrary values.
module iface_data_driver #(
  parameter int WIDTH = 32,
  parameter int STEP  = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  input  logic             load_en,
  input  logic [WIDTH-1:0] load_val,
  output logic             busy,
  output logic             done,
  I.D                      i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             busy_q, done_q;

  // Next-state, data and remaining-count computation.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    rem_d   = rem_q;
    case (state_q)
      IDLE: begin
        if (load_en) begin
          data_d = load_val;
        end else begin
          data_d = data_q;
        end
        if (start) begin
          if (count == {CNT_W{1'b0}}) begin
            state_d = DONE;
          end else begin
            state_d = RUN;
            rem_d   = count;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        // Carry out of the top bit is dropped: the sequence wraps modulo 2^WIDTH.
        data_d = data_q + STEP_W;
        rem_d  = rem_q - CNT_ONE;
        if (rem_q == CNT_ONE) begin
          state_d = DONE;
        end else begin
          state_d = RUN;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        data_d  = {WIDTH{1'b0}};
        rem_d   = {CNT_W{1'b0}};
      end
    endcase
  end

  // State, data and status registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= {WIDTH{1'b0}};
      rem_q   <= {CNT_W{1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      rem_q   <= rem_d;
      busy_q  <= (state_d == RUN) || (state_d == DONE);
      done_q  <= (state_d == DONE);
    end
  end

  assign i.data = data_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule
